// File: rtl/ahb_arbiter_if.sv
// AHB-Lite request/grant bundle between the master agents and the bus arbiter.
// Handshake: a master holds hbusreq until it sees its hgrant bit; every grant,
// hmaster and lock decision is accepted only on an hclk edge where hready = 1,
// so hready low freezes all arbitration-side state.
interface ahb_arbiter_if #(
  parameter int MASTER_NUM = 4
);
  logic [MASTER_NUM-1:0] hbusreq;
  logic [MASTER_NUM-1:0] hlock;
  logic                  hready;
  logic [MASTER_NUM-1:0] hgrant;
  logic [3:0]            hmaster;
  logic                  hmastlock;

  modport master (
    output hbusreq,
    output hlock,
    output hready,
    input  hgrant,
    input  hmaster,
    input  hmastlock
  );

  modport slave (
    input  hbusreq,
    input  hlock,
    input  hready,
    output hgrant,
    output hmaster,
    output hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB-Lite multi-master arbiter: one-hot registered grant, hmaster follow-up, lock FSM.
// Define AHB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module ahb_arbiter #(
  parameter int MASTER_NUM = 4
) (
  input  logic             hclk,
  input  logic             hreset,
  ahb_arbiter_if.slave     bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOCKED    = 2'd1,
    LOCK_TAIL = 2'd2
  } arb_state_t;

  localparam logic [MASTER_NUM-1:0] GRANT_ONE  = {{(MASTER_NUM-1){1'b0}}, 1'b1};
  localparam logic [MASTER_NUM-1:0] GRANT_DEF  = {1'b1, {(MASTER_NUM-1){1'b0}}};
  localparam logic [3:0]            MASTER_DEF = 4'(MASTER_NUM - 1);

  arb_state_t            state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [3:0]            hmaster_q;
  logic [3:0]            g_idx;
  logic [3:0]            win_idx;
  logic                  lock_g;
  logic                  any_req;
  logic                  arb_en;

  // The grant is one-hot, so masking hlock with it selects hlock[g].
  assign lock_g  = |(bus.hlock & grant_q);
  assign any_req = |bus.hbusreq;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_q[i]) g_idx = 4'(i);
    end
  end

`ifdef AHB_ARB_RR_EN
  logic [3:0] ptr_q, ptr_d;
  logic       found;

  // Walking 2*MASTER_NUM slots starting at the pointer gives the wrap-around search.
  always_comb begin
    win_idx = MASTER_DEF;
    found   = 1'b0;
    for (int i = 0; i < 2 * MASTER_NUM; i++) begin
      if (!found && (i >= int'(ptr_q)) && bus.hbusreq[i % MASTER_NUM]) begin
        win_idx = 4'(i % MASTER_NUM);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (bus.hready && (state_q == ARB) && !lock_g && any_req) begin
      ptr_d = (win_idx == MASTER_DEF) ? 4'd0 : win_idx + 4'd1;
    end
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) ptr_q <= 4'd0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = MASTER_DEF;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (bus.hbusreq[i]) win_idx = 4'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    if (bus.hready) begin
      case (state_q)
        ARB: begin
          if (lock_g) state_d = LOCKED;
          else        arb_en  = 1'b1;
        end
        LOCKED: begin
          if (!lock_g) state_d = LOCK_TAIL;
        end
        LOCK_TAIL: begin
          state_d = ARB;
          arb_en  = 1'b1;
        end
        default: state_d = ARB;
      endcase
    end
    grant_d = arb_en ? (GRANT_ONE << win_idx) : grant_q;
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q   <= ARB;
      grant_q   <= GRANT_DEF;
      hmaster_q <= MASTER_DEF;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (bus.hready) hmaster_q <= g_idx;
    end
  end

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hreset & lock_g;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed-vector bench for ahb_arbiter with MASTER_NUM = 4.
module tb_ahb_arbiter;

  logic       hclk;
  logic       hreset;
  logic [1:0] state_dbg;
  int         total;
  int         bad;

  ahb_arbiter_if #(.MASTER_NUM(4)) bus ();

  ahb_arbiter #(.MASTER_NUM(4)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic       rdy;
    logic [3:0] grant;
    logic [3:0] master;
    logic       mlock;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic rdy);
    @(negedge hclk);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.hready  = rdy;
  endtask

  task automatic do_reset();
    @(negedge hclk);
    hreset      = 1'b0;
    bus.hbusreq = 4'b0000;
    bus.hlock   = 4'b0000;
    bus.hready  = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b1;
  endtask

  logic [3:0] rr_grant [5];
  logic [3:0] rr_master [5];

  initial begin
    total       = 0;
    bad         = 0;
    hreset      = 1'b0;
    bus.hbusreq = 4'b0000;
    bus.hlock   = 4'b1000;
    bus.hready  = 1'b1;

    vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b1000, 4'd3, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b1000, 4'd3, 1'b0};
    vecs[2]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'd3, 1'b0};
    vecs[3]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 4'd3, 1'b0};
    vecs[4]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 4'd3, 1'b0};
    vecs[5]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 4'd3, 1'b0};
    vecs[6]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[7]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[8]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd1, 1'b0};
    vecs[9]  = '{4'b0111, 4'b0100, 1'b1, 4'b0100, 4'd2, 1'b1};
    vecs[10] = '{4'b0111, 4'b0100, 1'b0, 4'b0100, 4'd2, 1'b1};
    vecs[11] = '{4'b0111, 4'b0100, 1'b1, 4'b0100, 4'd2, 1'b1};
    vecs[12] = '{4'b0111, 4'b0100, 1'b1, 4'b0100, 4'd2, 1'b1};
    vecs[13] = '{4'b0111, 4'b0000, 1'b1, 4'b0100, 4'd2, 1'b0};
    vecs[14] = '{4'b0111, 4'b0000, 1'b1, 4'b0001, 4'd2, 1'b0};
    vecs[15] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'd0, 1'b0};
    vecs[16] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 4'd0, 1'b0};
    vecs[17] = '{4'b0000, 4'b0000, 1'b1, 4'b1000, 4'd3, 1'b0};
    vecs[18] = '{4'b0000, 4'b1000, 1'b1, 4'b1000, 4'd3, 1'b1};
    vecs[19] = '{4'b0001, 4'b0000, 1'b1, 4'b1000, 4'd3, 1'b0};
    vecs[20] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'd3, 1'b0};

`ifdef AHB_ARB_RR_EN
    rr_grant  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_master = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
`else
    rr_grant  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rr_master = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
`endif

    // reset values, with the default master's lock bit raised
    repeat (2) @(posedge hclk);
    #1;
    check("reset_grant", 32'(bus.hgrant), 32'h8);
    check("reset_master", 32'(bus.hmaster), 32'd3);
    check("reset_mastlock", 32'(bus.hmastlock), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge hclk);
    bus.hlock = 4'b0000;
    hreset    = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].req, vecs[i].lock, vecs[i].rdy);
      @(posedge hclk);
      #1;
      check($sformatf("v%0d_grant", i), 32'(bus.hgrant), 32'(vecs[i].grant));
      check($sformatf("v%0d_master", i), 32'(bus.hmaster), 32'(vecs[i].master));
      check($sformatf("v%0d_mastlock", i), 32'(bus.hmastlock), 32'(vecs[i].mlock));
      check($sformatf("v%0d_onehot", i), 32'($onehot(bus.hgrant)), 32'd1);
    end

    // asynchronous reset while master 0 holds a lock
    drive(4'b0001, 4'b0001, 1'b1);
    @(posedge hclk);
    #1;
    check("lock0_state", 32'(state_dbg), 32'd1);
    check("lock0_mastlock", 32'(bus.hmastlock), 32'd1);
    @(negedge hclk);
    #2;
    hreset = 1'b0;
    #1;
    check("async_grant", 32'(bus.hgrant), 32'h8);
    check("async_master", 32'(bus.hmaster), 32'd3);
    check("async_mastlock", 32'(bus.hmastlock), 32'd0);
    check("async_state", 32'(state_dbg), 32'd0);
    @(negedge hclk);
    hreset    = 1'b1;
    bus.hlock = 4'b0000;
    @(posedge hclk);
    #1;
    check("post_reset_grant", 32'(bus.hgrant), 32'h1);
    check("post_reset_master", 32'(bus.hmaster), 32'd3);

    // all masters requesting continuously from a fresh reset
    do_reset();
    bus.hbusreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge hclk);
      #1;
      check($sformatf("all_req%0d_grant", i), 32'(bus.hgrant), 32'(rr_grant[i]));
      check($sformatf("all_req%0d_master", i), 32'(bus.hmaster), 32'(rr_master[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
